chaotic_seq_ctrl: RTL and testbench

CHAOTIC_SEQ_CTRL -- requirements
Module: chaotic_seq_ctrl

---
 rtl/chaotic_pkg.sv | 16 +
 rtl/slot_addr_cnt.sv | 43 ++++
 rtl/chaotic_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_chaotic_seq_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/chaotic_pkg.sv
// Shared definitions for the chaotic-trajectory sequencer: FSM state
// encoding and default slot/address sizing.
package chaotic_pkg;

    localparam int SLOT_NUM_DEF = 243;
    localparam int ADDR_W_DEF   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/slot_addr_cnt.sv
// Slot address counter: steps 0..SLOT_NUM-1 while enabled and wraps to 0,
// with a one-cycle wrap pulse on the last slot.
module slot_addr_cnt
    import chaotic_pkg::*;
#(
    parameter int SLOT_NUM = SLOT_NUM_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              wrap_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SLOT_NUM - 1);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    assign wrap_o = en_i && (addr_q == LAST_ADDR);
    assign addr_o = addr_q;

    // clear has priority so an abort always lands on slot 0
    always_comb begin
        addr_d = addr_q;
        if (clr_i) begin
            addr_d = '0;
        end else if (en_i) begin
            addr_d = wrap_o ? '0 : addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/chaotic_seq_ctrl.sv
// Sequencer for an interleaved chaotic-map datapath: seeds the state RAM,
// issues iter_num passes over all slots, then drains outstanding results.
module chaotic_seq_ctrl
    import chaotic_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int SLOT_NUM   = SLOT_NUM_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int ITER_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ITER_W-1:0] iter_num,
    output logic              seed_sel,
    input  logic              n1_valid,
    output logic              n_valid,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              ram_we,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] pass_cnt
);

    localparam int OUT_W = ADDR_W + ITER_W;

    if (DATA_WIDTH < 1 || SLOT_NUM < 1 || SLOT_NUM > (1 << ADDR_W)) begin : g_bad_params
        $error("chaotic_seq_ctrl: illegal DATA_WIDTH/SLOT_NUM/ADDR_W combination");
    end

    seq_state_e        state_q;
    logic [ITER_W-1:0] iter_q;
    logic [ITER_W-1:0] pass_cnt_q;
    logic [OUT_W-1:0]  outst_q;
    logic [OUT_W-1:0]  outst_d;

    logic in_seed, in_run, in_drain, in_job;
    logic job_start, cnt_clr, result_ret;
    logic rd_wrap, wr_wrap;

    assign in_seed  = (state_q == ST_SEED);
    assign in_run   = (state_q == ST_RUN);
    assign in_drain = (state_q == ST_DRAIN);
    assign in_job   = in_seed || in_run || in_drain;

    assign job_start  = (state_q == ST_IDLE) && start && !abort;
    assign cnt_clr    = job_start || (in_job && abort);
    assign result_ret = (in_run || in_drain) && n1_valid;

    assign n_valid  = in_run && (pass_cnt_q != iter_q);
    assign ram_we   = in_seed || result_ret;
    assign seed_sel = in_seed;
    assign busy     = in_job;
    assign done     = (state_q == ST_DONE);
    assign pass_cnt = pass_cnt_q;

    slot_addr_cnt #(.SLOT_NUM(SLOT_NUM), .ADDR_W(ADDR_W)) u_rd_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .en_i   (n_valid),
        .addr_o (rd_addr),
        .wrap_o (rd_wrap)
    );

    slot_addr_cnt #(.SLOT_NUM(SLOT_NUM), .ADDR_W(ADDR_W)) u_wr_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .en_i   (ram_we),
        .addr_o (wr_addr),
        .wrap_o (wr_wrap)
    );

    // results can never outnumber issues, so a return at zero is not counted
    always_comb begin
        outst_d = outst_q;
        if (n_valid && !result_ret) begin
            outst_d = outst_q + OUT_W'(1);
        end else if (!n_valid && result_ret && (outst_q != '0)) begin
            outst_d = outst_q - OUT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            iter_q     <= '0;
            pass_cnt_q <= '0;
            outst_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (job_start) begin
                        iter_q     <= iter_num;
                        pass_cnt_q <= '0;
                        outst_q    <= '0;
                        state_q    <= ST_SEED;
                    end
                end
                ST_SEED: begin
                    if (abort) begin
                        outst_q <= '0;
                        state_q <= ST_IDLE;
                    end else if (wr_wrap) begin
                        state_q <= (iter_q == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        outst_q <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        outst_q <= outst_d;
                        if (rd_wrap) begin
                            pass_cnt_q <= pass_cnt_q + ITER_W'(1);
                        end
                        if (!n_valid) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        outst_q <= '0;
                        state_q <= ST_IDLE;
                    end else if (outst_q == '0) begin
                        state_q <= ST_DONE;
                    end else begin
                        outst_q <= outst_d;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chaotic_seq_ctrl.sv
// Directed bench for chaotic_seq_ctrl with SLOT_NUM=4 and a fixed 4-cycle
// datapath delay from n_valid to n1_valid.
module tb_chaotic_seq_ctrl;

    localparam int SLOT = 4;
    localparam int AW   = 8;
    localparam int IW   = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [IW-1:0] iter_num = '0;
    logic          seed_sel;
    logic          n1_valid;
    logic          n_valid;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    logic          ram_we;
    logic          busy;
    logic          done;
    logic [IW-1:0] pass_cnt;

    always #5 clk = ~clk;

    chaotic_seq_ctrl #(
        .DATA_WIDTH (64),
        .SLOT_NUM   (SLOT),
        .ADDR_W     (AW),
        .ITER_W     (IW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .iter_num (iter_num),
        .seed_sel (seed_sel),
        .n1_valid (n1_valid),
        .n_valid  (n_valid),
        .rd_addr  (rd_addr),
        .wr_addr  (wr_addr),
        .ram_we   (ram_we),
        .busy     (busy),
        .done     (done),
        .pass_cnt (pass_cnt)
    );

    // datapath model: fixed 4-cycle latency
    logic [3:0] pipe;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe <= '0;
        else        pipe <= {pipe[2:0], n_valid};
    end
    assign n1_valid = pipe[3];

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    int seed_wr, seed_err, run_wr, run_err, nv_cnt, done_cnt, pass_at_done;
    int addr_err = 0;

    always @(negedge clk) begin
        if (int'(rd_addr) >= SLOT || int'(wr_addr) >= SLOT) addr_err++;
        if (rst_n) begin
            if (ram_we && seed_sel) begin
                if (int'(wr_addr) != seed_wr) seed_err++;
                seed_wr++;
            end
            if (ram_we && !seed_sel) begin
                if (int'(wr_addr) != (run_wr % SLOT)) run_err++;
                run_wr++;
            end
            if (n_valid) nv_cnt++;
            if (done) begin
                done_cnt++;
                pass_at_done = int'(pass_cnt);
            end
        end
    end

    task automatic clear_stats();
        seed_wr = 0; seed_err = 0; run_wr = 0; run_err = 0;
        nv_cnt = 0; done_cnt = 0; pass_at_done = -1;
    endtask

    task automatic pulse_start(input logic [IW-1:0] it);
        @(posedge clk); #1;
        start = 1'b1;
        iter_num = it;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check(tag, done_cnt, 1);
    endtask

    initial begin
        int seen;
        clear_stats();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl_outs", {busy, done, n_valid, ram_we, seed_sel}, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_pass_cnt", pass_cnt, 0);
        #2 rst_n = 1'b1;

        // basic job, iter_num=2
        @(posedge clk); #1;
        clear_stats();
        pulse_start(16'd2);
        check("basic_busy", busy, 1);
        wait_done(200, "basic_done_once");
        check("basic_seed_wr", seed_wr, 4);
        check("basic_seed_order", seed_err, 0);
        check("basic_nvalid", nv_cnt, 8);
        check("basic_run_wr", run_wr, 8);
        check("basic_run_order", run_err, 0);
        check("basic_pass_at_done", pass_at_done, 2);
        check("basic_idle_busy", busy, 0);

        // zero iterations
        clear_stats();
        pulse_start(16'd0);
        wait_done(100, "zero_done_once");
        check("zero_seed_wr", seed_wr, 4);
        check("zero_nvalid", nv_cnt, 0);
        check("zero_run_wr", run_wr, 0);

        // start and abort together in IDLE
        clear_stats();
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; iter_num = 16'd2;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("startabort_busy", busy, 0);
        repeat (6) @(posedge clk);
        #1;
        check("startabort_seed_wr", seed_wr, 0);

        // abort on the third RUN cycle
        clear_stats();
        pulse_start(16'd3);
        seen = 0;
        for (int n = 0; n < 200 && seen < 3; n++) begin
            @(posedge clk); #1;
            if (n_valid) seen++;
        end
        check("abort_reach_run3", seen, 3);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy_next", busy, 0);
        check("abort_rd_addr", rd_addr, 0);
        check("abort_wr_addr", wr_addr, 0);
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, 0);
        check("abort_no_late_we", run_wr, 0);

        // start during RUN is ignored
        clear_stats();
        pulse_start(16'd2);
        seen = 0;
        for (int n = 0; n < 200 && seen < 2; n++) begin
            @(posedge clk); #1;
            if (n_valid) seen++;
        end
        start = 1'b1; iter_num = 16'd5;
        @(posedge clk); #1;
        start = 1'b0; iter_num = 16'd0;
        wait_done(200, "ign_done_once");
        check("ign_nvalid", nv_cnt, 8);
        check("ign_pass_at_done", pass_at_done, 2);
        check("ign_run_wr", run_wr, 8);

        // reset during DRAIN, then a fresh job
        clear_stats();
        pulse_start(16'd2);
        seen = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (n_valid) seen = 1;
            else if (seen == 1 && busy) break;
        end
        @(posedge clk); #1;
        check("mid_in_drain", {busy, n_valid, seed_sel}, 3'b100);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ctrl_outs", {busy, done, n_valid, ram_we, seed_sel}, 0);
        check("mid_rst_rd_addr", rd_addr, 0);
        check("mid_rst_wr_addr", wr_addr, 0);
        check("mid_rst_pass_cnt", pass_cnt, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("mid_no_done", done_cnt, 0);
        clear_stats();
        pulse_start(16'd1);
        wait_done(200, "post_done_once");
        check("post_seed_wr", seed_wr, 4);
        check("post_nvalid", nv_cnt, 4);
        check("post_run_wr", run_wr, 4);
        check("post_run_order", run_err, 0);
        check("post_pass_at_done", pass_at_done, 1);

        check("addr_in_range", addr_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
